// File: rtl/accelbrot_mult_arbiter.sv
// Round-robin arbiter sharing one pipelined WWIDTH x WWIDTH multiplier between NUM_REQ requesters.
// Per-requester grant counters are built only when ACCELBROT_MULT_ARB_STATS_EN is defined.
module accelbrot_mult_arbiter #(
  parameter int WWIDTH       = 34,
  parameter int NUM_REQ      = 4,
  parameter int MULT_LATENCY = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      hold,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*WWIDTH-1:0] req_a,
  input  logic [NUM_REQ*WWIDTH-1:0] req_b,
  output logic [WWIDTH-1:0]         mult_a,
  output logic [WWIDTH-1:0]         mult_b,
  output logic                      mult_cea,
  output logic                      mult_ceb,
  input  logic [2*WWIDTH-1:0]       mult_q,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [2*WWIDTH-1:0]       rsp_q,
  output logic                      busy,
  output logic [NUM_REQ*32-1:0]     stat_grants
);

  localparam int              PW   = $clog2(NUM_REQ);
  localparam logic [PW:0]     NREQ = (PW+1)'(NUM_REQ);
  localparam logic [PW-1:0]   LAST = PW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  logic [PW-1:0]           rr_ptr;
  logic                    grant_vld;
  logic [PW-1:0]           grant_idx;
  logic [PW:0]             cand;
  logic [MULT_LATENCY-1:0] tag_vld;
  logic [PW-1:0]           tag_idx [MULT_LATENCY];

  // Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (PW+1)'(k);
      if (cand >= NREQ) cand = cand - NREQ;
      if (!grant_vld && req_valid[cand[PW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[PW-1:0];
      end
    end
    if (hold || rst) begin
      grant_vld = 1'b0;
      grant_idx = '0;
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_vld) req_ready[grant_idx] = 1'b1;
  end

  assign mult_a   = grant_vld ? req_a[grant_idx*WWIDTH +: WWIDTH] : '0;
  assign mult_b   = grant_vld ? req_b[grant_idx*WWIDTH +: WWIDTH] : '0;
  assign mult_cea = grant_vld;
  assign mult_ceb = grant_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_vld) begin
      rr_ptr <= (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
    end
  end

  // Tags shift unconditionally so they stay aligned with the non-stallable multiplier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld <= '0;
      for (int i = 0; i < MULT_LATENCY; i++) tag_idx[i] <= '0;
    end else begin
      tag_vld[0] <= grant_vld;
      tag_idx[0] <= grant_idx;
      for (int i = 1; i < MULT_LATENCY; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_q     <= '0;
    end else if (tag_vld[MULT_LATENCY-1]) begin
      rsp_valid <= ONE << tag_idx[MULT_LATENCY-1];
      rsp_q     <= mult_q;
    end else begin
      rsp_valid <= '0;
    end
  end

  assign busy = (|tag_vld) || (|rsp_valid);

`ifdef ACCELBROT_MULT_ARB_STATS_EN
  logic [31:0] stat_cnt [NUM_REQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) stat_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i] && (stat_cnt[i] != 32'hFFFF_FFFF))
          stat_cnt[i] <= stat_cnt[i] + 32'd1;
      end
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < NUM_REQ; i++) stat_grants[i*32 +: 32] = stat_cnt[i];
  end
`else
  assign stat_grants = '0;
`endif

endmodule

// File: tb/tb_accelbrot_mult_arbiter.sv
// Bench for accelbrot_mult_arbiter: directed scenarios plus randomized traffic against a queue model.
`timescale 1ns/1ps
module tb_accelbrot_mult_arbiter;
  localparam int W = 34;
  localparam int N = 4;
  localparam int L = 4;
`ifdef ACCELBROT_MULT_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    int             due;
    int             idx;
    logic [2*W-1:0] prod;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           hold = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [W-1:0]   a_arr [N];
  logic [W-1:0]   b_arr [N];
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_ready, rsp_valid;
  logic [W-1:0]   mult_a, mult_b;
  logic           mult_cea, mult_ceb;
  logic [2*W-1:0] mult_q, rsp_q;
  logic           busy;
  logic [N*32-1:0] stat_grants;
  logic [2*W-1:0] m_pipe [L];

  int checks = 0;
  int failures = 0;
  int rr_model;
  int grant_cnt [N];

  always #5 clk = ~clk;

  assign req_a = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};
  assign req_b = {b_arr[3], b_arr[2], b_arr[1], b_arr[0]};

  function automatic logic [2*W-1:0] mul(input logic [W-1:0] a, input logic [W-1:0] b);
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction

  // Behavioural stand-in for the shared multiplier: 4 registered stages, no reset.
  always @(posedge clk) begin
    if (mult_cea) m_pipe[0] <= mul(mult_a, mult_b);
    for (int i = 1; i < L; i++) m_pipe[i] <= m_pipe[i-1];
  end
  assign mult_q = m_pipe[L-1];

  accelbrot_mult_arbiter #(.WWIDTH(W), .NUM_REQ(N), .MULT_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mult_a(mult_a), .mult_b(mult_b), .mult_cea(mult_cea), .mult_ceb(mult_ceb),
    .mult_q(mult_q),
    .rsp_valid(rsp_valid), .rsp_q(rsp_q),
    .busy(busy), .stat_grants(stat_grants)
  );

  function automatic logic [W-1:0] rnd_op();
    if ($urandom_range(0, 7) == 0) return '1;
    return W'({$urandom(), $urandom()});
  endfunction

  task automatic rnd_ops();
    for (int i = 0; i < N; i++) begin
      a_arr[i] = rnd_op();
      b_arr[i] = rnd_op();
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; hold = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rr_model = 0;
    for (int i = 0; i < N; i++) grant_cnt[i] = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '1; hold = 1'b0;
    #1;
    checks++; if (req_ready !== '0) begin failures++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
    checks++; if (rsp_valid !== '0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_q !== '0) begin failures++; $display("FAIL reset_rsp_q got=%h exp=0", rsp_q); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (stat_grants !== '0) begin failures++; $display("FAIL reset_stats got=%h exp=0", stat_grants); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL reset_rr_start got=%b exp=0001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_single();
    apply_reset();
    rnd_ops();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      req_valid = (k == 0) ? 4'b0100 : 4'b0000;
      if (k == 0) begin a_arr[2] = 34'd3; b_arr[2] = 34'd5; end
      #1;
      if (k == 0) begin
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
        checks++; if (mult_cea !== 1'b1 || mult_ceb !== 1'b1) begin failures++; $display("FAIL single_ce got=%b%b exp=11", mult_cea, mult_ceb); end
        checks++; if (mult_a !== 34'd3 || mult_b !== 34'd5) begin failures++; $display("FAIL single_ops got=%0d,%0d exp=3,5", mult_a, mult_b); end
      end
      checks++;
      if (rsp_valid !== ((k == 5) ? 4'b0100 : 4'b0000)) begin failures++; $display("FAIL single_rsp_valid k=%0d got=%b", k, rsp_valid); end
      if (k == 5) begin
        checks++; if (rsp_q !== 68'd15) begin failures++; $display("FAIL single_rsp_q got=%0d exp=15", rsp_q); end
      end
    end
  endtask

  task automatic test_max_operands();
    logic [2*W-1:0] expv;
    expv = 68'hFFFFFFFF800000001;
    apply_reset();
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      req_valid = (k == 0) ? 4'b0001 : 4'b0000;
      a_arr[0] = '1; b_arr[0] = '1;
      #1;
      if (k == 5) begin
        checks++; if (rsp_valid !== 4'b0001 || rsp_q !== expv) begin failures++; $display("FAIL max_ops got=%b/%h exp=0001/%h", rsp_valid, rsp_q, expv); end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [2*W-1:0] expp [8];
    apply_reset();
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      rnd_ops();
      req_valid = (k < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (k < 8) begin
        expp[k] = mul(a_arr[k % 4], b_arr[k % 4]);
        checks++; if (req_ready !== 4'(1 << (k % 4))) begin failures++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, req_ready, 4'(1 << (k % 4))); end
      end
      if (k >= 5 && k < 13) begin
        checks++;
        if (rsp_valid !== 4'(1 << ((k - 5) % 4)) || rsp_q !== expp[k-5]) begin
          failures++; $display("FAIL rr_rsp k=%0d got=%b/%h exp=%b/%h", k, rsp_valid, rsp_q, 4'(1 << ((k - 5) % 4)), expp[k-5]);
        end
      end else begin
        checks++; if (rsp_valid !== '0) begin failures++; $display("FAIL rr_rsp_idle k=%0d got=%b exp=0", k, rsp_valid); end
      end
    end
  endtask

  task automatic test_hold();
    logic [2*W-1:0] p0, p2;
    logic [N-1:0] er;
    apply_reset();
    rnd_ops();
    p0 = mul(a_arr[0], b_arr[0]);
    p2 = mul(a_arr[2], b_arr[2]);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      req_valid = (k >= 1 && k <= 3) ? 4'b0101 : 4'b0000;
      hold = (k == 3);
      #1;
      er = (k == 1) ? 4'b0001 : (k == 2) ? 4'b0100 : 4'b0000;
      checks++; if (req_ready !== er) begin failures++; $display("FAIL hold_grant k=%0d got=%b exp=%b", k, req_ready, er); end
      if (k == 3) begin
        checks++; if (mult_cea !== 1'b0) begin failures++; $display("FAIL hold_cea got=%b exp=0", mult_cea); end
      end
      checks++; if (busy !== (k >= 2 && k <= 7)) begin failures++; $display("FAIL hold_busy k=%0d got=%b", k, busy); end
      if (k == 6) begin
        checks++; if (rsp_valid !== 4'b0001 || rsp_q !== p0) begin failures++; $display("FAIL hold_rsp0 got=%b/%h exp=0001/%h", rsp_valid, rsp_q, p0); end
      end else if (k == 7) begin
        checks++; if (rsp_valid !== 4'b0100 || rsp_q !== p2) begin failures++; $display("FAIL hold_rsp2 got=%b/%h exp=0100/%h", rsp_valid, rsp_q, p2); end
      end else begin
        checks++; if (rsp_valid !== '0) begin failures++; $display("FAIL hold_rsp_idle k=%0d got=%b", k, rsp_valid); end
      end
    end
    hold = 1'b0;
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      rnd_ops();
      rst = (k == 2);
      req_valid = (k == 0) ? 4'b0010 : (k == 1) ? 4'b1000 : (k == 2 || k == 11) ? 4'b1111 : 4'b0000;
      #1;
      if (k == 0) begin
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL rstmid_g0 got=%b exp=0010", req_ready); end
      end else if (k == 1) begin
        checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL rstmid_g1 got=%b exp=1000", req_ready); end
      end else if (k == 2) begin
        checks++; if (req_ready !== '0) begin failures++; $display("FAIL rstmid_ready got=%b exp=0", req_ready); end
      end else if (k == 11) begin
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL rstmid_rr got=%b exp=0001", req_ready); end
      end
      if (k >= 2 && k <= 10) begin
        checks++; if (rsp_valid !== '0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_quiet k=%0d got=%b/%b exp=0/0", k, rsp_valid, busy); end
      end
    end
  endtask

  task automatic test_stats();
    int expc [N];
    apply_reset();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      req_valid = (k < 10) ? 4'b0010 : (k < 13) ? 4'b1000 : 4'b0000;
      #1;
    end
    expc[0] = 0; expc[1] = STATS ? 10 : 0; expc[2] = 0; expc[3] = STATS ? 3 : 0;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (stat_grants[i*32 +: 32] !== 32'(expc[i])) begin failures++; $display("FAIL stats_slice%0d got=%0d exp=%0d", i, stat_grants[i*32 +: 32], expc[i]); end
    end
  endtask

  task automatic test_random();
    exp_t q [$];
    exp_t e;
    int g;
    logic [N-1:0] er;
    apply_reset();
    for (int t = 0; t < 408; t++) begin
      @(negedge clk);
      rnd_ops();
      if (t < 400) begin
        req_valid = 4'($urandom_range(0, 15));
        hold = ($urandom_range(0, 4) == 0);
      end else begin
        req_valid = '0;
        hold = 1'b0;
      end
      #1;
      g = -1;
      if (!hold) begin
        for (int k = N - 1; k >= 0; k--) if (req_valid[(rr_model + k) % N]) g = (rr_model + k) % N;
      end
      er = (g >= 0) ? 4'(1 << g) : 4'b0000;
      checks++; if (req_ready !== er) begin failures++; $display("FAIL rand_ready t=%0d got=%b exp=%b", t, req_ready, er); end
      checks++; if (mult_cea !== (g >= 0) || mult_ceb !== (g >= 0)) begin failures++; $display("FAIL rand_ce t=%0d got=%b%b", t, mult_cea, mult_ceb); end
      if (g >= 0) begin
        checks++; if (mult_a !== a_arr[g] || mult_b !== b_arr[g]) begin failures++; $display("FAIL rand_ops t=%0d got=%h,%h exp=%h,%h", t, mult_a, mult_b, a_arr[g], b_arr[g]); end
      end
      checks++; if (busy !== (q.size() > 0)) begin failures++; $display("FAIL rand_busy t=%0d got=%b exp=%b", t, busy, q.size() > 0); end
      if (q.size() > 0 && q[0].due == t) begin
        e = q.pop_front();
        checks++;
        if (rsp_valid !== 4'(1 << e.idx) || rsp_q !== e.prod) begin
          failures++; $display("FAIL rand_rsp t=%0d got=%b/%h exp=%b/%h", t, rsp_valid, rsp_q, 4'(1 << e.idx), e.prod);
        end
      end else begin
        checks++; if (rsp_valid !== '0) begin failures++; $display("FAIL rand_rsp_idle t=%0d got=%b exp=0", t, rsp_valid); end
      end
      if (g >= 0) begin
        e.due = t + L + 1; e.idx = g; e.prod = mul(a_arr[g], b_arr[g]);
        q.push_back(e);
        rr_model = (g + 1) % N;
        grant_cnt[g]++;
      end
    end
    checks++; if (q.size() != 0) begin failures++; $display("FAIL rand_drain got=%0d pending exp=0", q.size()); end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (stat_grants[i*32 +: 32] !== (STATS ? 32'(grant_cnt[i]) : 32'd0)) begin
        failures++; $display("FAIL rand_stats%0d got=%0d exp=%0d", i, stat_grants[i*32 +: 32], STATS ? grant_cnt[i] : 0);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      a_arr[i] = '0; b_arr[i] = '0; grant_cnt[i] = 0;
    end
    rr_model = 0;
    test_reset();
    test_single();
    test_max_operands();
    test_round_robin();
    test_hold();
    test_reset_midflight();
    test_stats();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
